// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/RAM bundle between datapath, arbiter and RAM port
// slave is the arbiter's view; master is the requester/RAM side that drives it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;
  logic [1:0]        grant;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, grant
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter, data priority with instruction starvation guard
// Arbitration happens in IDLE and on the completing/withdrawn cycle of a grant, so grants chain without bubbles.
module mem_arbiter #(
  parameter int DSTARVE_MAX = 4
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(DSTARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(DSTARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    INSTR = 2'b01,
    DATA  = 2'b10
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     starve_cnt, starve_nxt;
  logic              d_req, arb, force_i;
  logic              ren, wen, ih, dh;
  logic [$bits(bus.ramaddr)-1:0]  addr;
  logic [$bits(bus.ramstore)-1:0] store, il, dl;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    wen       = 1'b0;
    ih        = 1'b0;
    dh        = 1'b0;
    addr      = '0;
    store     = '0;
    il        = '0;
    dl        = '0;
    arb       = 1'b0;
    d_req     = bus.dREN | bus.dWEN;

    case (state)
      IDLE: arb = 1'b1;
      DATA: begin
        if (d_req) begin
          addr  = bus.daddr;
          store = bus.dstore;
          wen   = bus.dWEN;
          ren   = ~bus.dWEN;
          if (bus.ram_ready) begin
            dh  = 1'b1;
            dl  = bus.dWEN ? '0 : bus.ramload;
            arb = 1'b1;
          end
        end else begin
          arb = 1'b1;
        end
      end
      INSTR: begin
        if (bus.iREN) begin
          ren  = 1'b1;
          addr = bus.iaddr;
          if (bus.ram_ready) begin
            ih  = 1'b1;
            il  = bus.ramload;
            arb = 1'b1;
          end
        end else begin
          arb = 1'b1;
        end
      end
      default: arb = 1'b1;
    endcase

    if (!bus.iREN || ih)
      starve_nxt = '0;
    else if (dh && starve_cnt != SMAX)
      starve_nxt = starve_cnt + CW'(1);
    else
      starve_nxt = starve_cnt;

    // Force uses the post-hit count so the DSTARVE_MAX-th dhit hands off straight to INSTR.
    force_i = bus.iREN && (starve_nxt == SMAX);

    if (arb) begin
      if (force_i)         state_nxt = INSTR;
      else if (d_req)      state_nxt = DATA;
      else if (bus.iREN)   state_nxt = INSTR;
      else                 state_nxt = IDLE;
    end
  end

  assign bus.ramREN   = ren & ~RST;
  assign bus.ramWEN   = wen & ~RST;
  assign bus.ihit     = ih & ~RST;
  assign bus.dhit     = dh & ~RST;
  assign bus.ramaddr  = RST ? '0 : addr;
  assign bus.ramstore = RST ? '0 : store;
  assign bus.iload    = RST ? '0 : il;
  assign bus.dload    = RST ? '0 : dl;
  assign bus.grant    = RST ? 2'b00 : state;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter
module tb_mem_arbiter;
  logic CLK;
  logic RST;
  int   tests;
  int   fails;

  localparam logic [31:0] IA = 32'h0000_0040;
  localparam logic [31:0] DA = 32'h0000_0100;
  localparam logic [31:0] DS = 32'hDEAD_BEEF;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.DSTARVE_MAX(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, iren, dren, dwen, rdy;
    logic [31:0] rl;
    logic        rel;
    logic [1:0]  g;
    logic        ih, dh, rn, wn;
    logic [31:0] il, dl, ad, st;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic rst, iren, dren, dwen, rdy, input logic [31:0] rl,
                              input logic rel, input logic [1:0] g, input logic ih, dh, rn, wn,
                              input logic [31:0] il, dl, ad, st);
    vec_t v;
    v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen; v.rdy = rdy; v.rl = rl;
    v.rel = rel; v.g = g; v.ih = ih; v.dh = dh; v.rn = rn; v.wn = wn;
    v.il = il; v.dl = dl; v.ad = ad; v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int nd;
    logic got_i;
    tests = 0;
    fails = 0;
    RST = 1'b1;
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ram_ready = 0;
    bus.iaddr = IA; bus.daddr = DA; bus.dstore = DS; bus.ramload = '0;

    //        rst i d w rdy ramload        rel g    ih dh rn wn iload          dload          addr st
    tv.push_back(mk(1,1,1,0,1, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,1,1,0,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,1,1,0,0, 32'h0,        0, 2'd2, 0,0,1,0, 32'h0,         32'h0,         DA, DS));
    tv.push_back(mk(1,0,0,0,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,0,0,0,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,1,0,0,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,1,0,0,0, 32'h0,        0, 2'd1, 0,0,1,0, 32'h0,         32'h0,         IA, 0));
    tv.push_back(mk(0,1,0,0,0, 32'h0,        0, 2'd1, 0,0,1,0, 32'h0,         32'h0,         IA, 0));
    tv.push_back(mk(0,1,0,0,1, 32'h8C220004, 1, 2'd1, 1,0,1,0, 32'h8C220004,  32'h0,         IA, 0));
    tv.push_back(mk(0,0,0,0,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,0,1,0,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,0,1,0,0, 32'h0,        0, 2'd2, 0,0,1,0, 32'h0,         32'h0,         DA, DS));
    tv.push_back(mk(0,0,0,0,1, 32'h55,       0, 2'd2, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,0,0,0,1, 32'h123,      0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,0,1,1,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,0,1,1,1, 32'h777,      1, 2'd2, 0,1,0,1, 32'h0,         32'h0,         DA, DS));
    tv.push_back(mk(0,0,0,0,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,0,1,0,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));
    tv.push_back(mk(0,0,1,0,1, 32'hCAFEF00D, 1, 2'd2, 0,1,1,0, 32'h0,         32'hCAFEF00D,  DA, DS));
    tv.push_back(mk(0,0,0,0,0, 32'h0,        0, 2'd0, 0,0,0,0, 32'h0,         32'h0,         0,  0));

    foreach (tv[i]) begin
      tick();
      RST = tv[i].rst; bus.iREN = tv[i].iren; bus.dREN = tv[i].dren; bus.dWEN = tv[i].dwen;
      bus.ram_ready = tv[i].rdy; bus.ramload = tv[i].rl;
      #3;
      chk($sformatf("row%0d grant", i), {30'd0, bus.grant}, {30'd0, tv[i].g});
      chk($sformatf("row%0d ihit", i), {31'd0, bus.ihit}, {31'd0, tv[i].ih});
      chk($sformatf("row%0d dhit", i), {31'd0, bus.dhit}, {31'd0, tv[i].dh});
      chk($sformatf("row%0d ramREN", i), {31'd0, bus.ramREN}, {31'd0, tv[i].rn});
      chk($sformatf("row%0d ramWEN", i), {31'd0, bus.ramWEN}, {31'd0, tv[i].wn});
      chk($sformatf("row%0d iload", i), bus.iload, tv[i].il);
      chk($sformatf("row%0d dload", i), bus.dload, tv[i].dl);
      chk($sformatf("row%0d ramaddr", i), bus.ramaddr, tv[i].ad);
      chk($sformatf("row%0d ramstore", i), bus.ramstore, tv[i].st);
      if (tv[i].rel) begin
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
      end
    end

    // Collision: data wins, instruction follows on the dhit cycle.
    tick(); bus.iREN = 1; bus.dWEN = 1; bus.ram_ready = 0; #3;
    chk("t3 idle grant", {30'd0, bus.grant}, 32'd0);
    tick(); #3;
    chk("t3 data grant", {30'd0, bus.grant}, 32'd2);
    chk("t3 ramWEN", {31'd0, bus.ramWEN}, 32'd1);
    chk("t3 ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("t3 ramstore", bus.ramstore, DS);
    chk("t3 ramaddr", bus.ramaddr, DA);
    tick(); bus.ram_ready = 1; #3;
    chk("t3 dhit", {31'd0, bus.dhit}, 32'd1);
    chk("t3 ihit low", {31'd0, bus.ihit}, 32'd0);
    bus.dWEN = 0;
    tick(); bus.ramload = 32'h2402000A; #3;
    chk("t3 instr grant", {30'd0, bus.grant}, 32'd1);
    chk("t3 instr addr", bus.ramaddr, IA);
    chk("t3 ihit", {31'd0, bus.ihit}, 32'd1);
    chk("t3 iload", bus.iload, 32'h2402000A);
    bus.iREN = 0;
    tick(); bus.ram_ready = 0; #3;
    chk("t3 back idle", {30'd0, bus.grant}, 32'd0);

    // Starvation: iREN held behind a continuous data stream.
    tick(); bus.iREN = 1; bus.dREN = 1; bus.ram_ready = 1; bus.ramload = 32'h1111_2222; #3;
    chk("t4 idle grant", {30'd0, bus.grant}, 32'd0);
    nd = 0;
    got_i = 0;
    for (int c = 0; c < 20 && !got_i; c++) begin
      tick(); #3;
      if (bus.ihit) begin
        got_i = 1;
        chk("t4 starve_cnt at force", {29'd0, dut.starve_cnt}, 32'd4);
      end else if (bus.dhit) begin
        nd++;
      end
    end
    chk("t4 ihit seen", {31'd0, got_i}, 32'd1);
    chk("t4 dhit count", nd, 32'd4);
    tick(); #3;
    chk("t4 starve_cnt cleared", {29'd0, dut.starve_cnt}, 32'd0);
    chk("t4 data after instr", {30'd0, bus.grant}, 32'd2);
    bus.iREN = 0; bus.dREN = 0;
    tick(); bus.ram_ready = 0; #3;
    chk("t4 idle", {30'd0, bus.grant}, 32'd0);

    // Reset during a completing instruction access.
    tick(); bus.iREN = 1; #3;
    chk("t6 idle grant", {30'd0, bus.grant}, 32'd0);
    tick(); #3;
    chk("t6 instr grant", {30'd0, bus.grant}, 32'd1);
    tick(); RST = 1; bus.ram_ready = 1; bus.ramload = 32'h3333_4444; #3;
    chk("t6 no ihit", {31'd0, bus.ihit}, 32'd0);
    chk("t6 no iload", bus.iload, 32'd0);
    chk("t6 ramREN off", {31'd0, bus.ramREN}, 32'd0);
    chk("t6 grant off", {30'd0, bus.grant}, 32'd0);
    tick(); RST = 0; bus.iREN = 0; bus.ram_ready = 0; #3;
    chk("t6 idle after reset", {30'd0, bus.grant}, 32'd0);
    chk("t6 starve_cnt reset", {29'd0, dut.starve_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
